// File: rtl/wb_arbiter_if.sv
// Execute-pipe result and register-file write-port bundle for wb_arbiter.
// master = pipes/register-file side, slave = arbiter side.
interface wb_arbiter_if #(
   parameter int unsigned NUM_FUS = 4,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned DATA_W  = 32
);
   logic [NUM_FUS-1:0]             fu_valid;
   logic [NUM_FUS-1:0][REG_W-1:0]  fu_dst;
   logic [NUM_FUS-1:0][DATA_W-1:0] fu_val;
   logic [NUM_FUS-1:0]             fu_ready;
   logic                           rf_we;
   logic [REG_W-1:0]               rf_waddr;
   logic [DATA_W-1:0]              rf_wdata;
   logic                           rf_ready;

   modport master (
      output fu_valid, fu_dst, fu_val, rf_ready,
      input  fu_ready, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  fu_valid, fu_dst, fu_val, rf_ready,
      output fu_ready, rf_we, rf_waddr, rf_wdata
   );
endinterface

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter: NUM_FUS pipes share one register-file write port.
// Optional ungranted-request counter enabled by WB_PERF_CNT_EN.
module wb_arbiter #(
   parameter int unsigned NUM_FUS = 4,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned DATA_W  = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   wb_arbiter_if.slave   bus
`ifdef WB_PERF_CNT_EN
   ,
   output logic [31:0]   conflict_cnt
`endif
);

   localparam int unsigned PTR_W = (NUM_FUS > 1) ? $clog2(NUM_FUS) : 1;

   logic [NUM_FUS-1:0] req;
   logic [NUM_FUS-1:0] drop;
   logic [NUM_FUS-1:0] grant;
   logic               gnt_any;
   logic [PTR_W-1:0]   gnt_idx;
   logic               out_free;

   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic               rf_we_q, rf_we_d;
   logic [REG_W-1:0]   rf_waddr_q, rf_waddr_d;
   logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

   always_comb begin
      req  = '0;
      drop = '0;
      for (int unsigned i = 0; i < NUM_FUS; i++) begin
         req[i]  = bus.fu_valid[i] && (bus.fu_dst[i] != '0);
         drop[i] = bus.fu_valid[i] && (bus.fu_dst[i] == '0);
      end
   end

   assign out_free = !rf_we_q || bus.rf_ready;

   // Rotating scan from rr_ptr; first set request wins.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      grant   = '0;
      if (out_free) begin
         for (int unsigned k = 0; k < NUM_FUS; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_FUS) idx = idx - NUM_FUS;
            if (!gnt_any && req[idx]) begin
               gnt_any = 1'b1;
               gnt_idx = PTR_W'(idx);
            end
         end
      end
      if (gnt_any) grant[gnt_idx] = 1'b1;
   end

   // x0 results complete regardless of arbitration; nothing accepts during reset.
   assign bus.fu_ready = rst_n ? (grant | drop) : '0;

   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      rf_we_d    = rf_we_q;
      rf_waddr_d = rf_waddr_q;
      rf_wdata_d = rf_wdata_q;
      if (gnt_any) begin
         rr_ptr_d   = (gnt_idx == PTR_W'(NUM_FUS - 1)) ? '0 : gnt_idx + PTR_W'(1);
         rf_we_d    = 1'b1;
         rf_waddr_d = bus.fu_dst[gnt_idx];
         rf_wdata_d = bus.fu_val[gnt_idx];
      end else if (rf_we_q && bus.rf_ready) begin
         rf_we_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q   <= '0;
         rf_we_q    <= 1'b0;
         rf_waddr_q <= '0;
         rf_wdata_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         rf_we_q    <= rf_we_d;
         rf_waddr_q <= rf_waddr_d;
         rf_wdata_q <= rf_wdata_d;
      end
   end

   assign bus.rf_we    = rf_we_q;
   assign bus.rf_waddr = rf_waddr_q;
   assign bus.rf_wdata = rf_wdata_q;

`ifdef WB_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts cycles with any waiting write request, including output-stall cycles.
   always_comb begin
      cnt_d = cnt_q;
      if (|(req & ~grant) && (cnt_q != '1)) cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign conflict_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: reference grant model feeding a write scoreboard.
// Build with WB_PERF_CNT_EN defined to also check conflict_cnt.
module tb_wb_arbiter;
   localparam int unsigned NF = 4;
   localparam int unsigned RW = 5;
   localparam int unsigned DW = 32;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb_arbiter_if #(.NUM_FUS(NF), .REG_W(RW), .DATA_W(DW)) bus ();
`ifdef WB_PERF_CNT_EN
   logic [31:0] conflict_cnt;
`endif

   wb_arbiter #(.NUM_FUS(NF), .REG_W(RW), .DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef WB_PERF_CNT_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic [RW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   wr_t          sb[$];
   logic         m_we  = 1'b0;
   int unsigned  m_ptr = 0;
   logic [31:0]  m_cnt = '0;
   logic [NF-1:0] xfer = '0;

   // Reference model: evaluated mid-cycle, predicts this cycle's accepts and the next write.
   always @(negedge clk) begin : model
      logic [NF-1:0] exp_rdy;
      logic [NF-1:0] rq;
      logic [NF-1:0] gmask;
      logic          ofree;
      bit            found;
      int unsigned   g;
      if (!rst_n) begin
         check("rst_fu_ready", 64'(bus.fu_ready), 64'd0);
         check("rst_rf_we", 64'(bus.rf_we), 64'd0);
         m_we  = 1'b0;
         m_ptr = 0;
         m_cnt = '0;
         sb.delete();
         xfer  = '0;
      end else begin
         check("rf_we", 64'(bus.rf_we), 64'(m_we));
         if (m_we) begin
            if (sb.size() == 0) begin
               check("sb_empty", 64'd1, 64'd0);
            end else begin
               check("rf_waddr", 64'(bus.rf_waddr), 64'(sb[0].a));
               check("rf_wdata", 64'(bus.rf_wdata), 64'(sb[0].d));
               if (bus.rf_ready) void'(sb.pop_front());
            end
         end
`ifdef WB_PERF_CNT_EN
         check("conflict_cnt", 64'(conflict_cnt), 64'(m_cnt));
`endif
         exp_rdy = '0;
         rq      = '0;
         for (int unsigned i = 0; i < NF; i++) begin
            if (bus.fu_valid[i]) begin
               if (bus.fu_dst[i] == '0) exp_rdy[i] = 1'b1;
               else                     rq[i] = 1'b1;
            end
         end
         ofree = !m_we || bus.rf_ready;
         found = 0;
         g     = m_ptr;
         if (ofree) begin
            for (int unsigned n = 0; n < NF && !found; n++) begin
               if (rq[g]) found = 1;
               else       g = (g + 1) % NF;
            end
         end
         gmask = '0;
         if (found) begin
            gmask[g]   = 1'b1;
            exp_rdy[g] = 1'b1;
            sb.push_back({bus.fu_dst[g], bus.fu_val[g]});
            m_ptr = (g + 1) % NF;
            m_we  = 1'b1;
         end else if (bus.rf_ready) begin
            m_we = 1'b0;
         end
         if (((rq & ~gmask) != '0) && (m_cnt != '1)) m_cnt = m_cnt + 32'd1;
         check("fu_ready", 64'(bus.fu_ready), 64'(exp_rdy));
         xfer = bus.fu_valid & bus.fu_ready;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      for (int unsigned i = 0; i < NF; i++)
         if (xfer[i]) bus.fu_valid[i] = 1'b0;
   endtask

   task automatic put(input int unsigned i, input logic [RW-1:0] dst, input logic [DW-1:0] val);
      bus.fu_valid[i] = 1'b1;
      bus.fu_dst[i]   = dst;
      bus.fu_val[i]   = val;
   endtask

   task automatic drain(input string tag);
      for (int unsigned n = 0; n < 40; n++) begin
         if (bus.fu_valid == '0 && !bus.rf_we) break;
         tick();
      end
      check(tag, {62'd0, |bus.fu_valid, bus.rf_we}, 64'd0);
      check({tag, "_sb"}, 64'(sb.size()), 64'd0);
   endtask

   task automatic reset_pulse();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      bus.fu_valid = '0;
      bus.fu_dst   = '0;
      bus.fu_val   = '0;
      bus.rf_ready = 1'b1;
      tick();
      check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
      check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
      tick();
      rst_n = 1'b1;

      // single write, then search resumes after FU1
      put(1, 5'd5, 32'hDEADBEEF);
      #1 check("t1_ready", 64'(bus.fu_ready), 64'h2);
      tick();
      check("t1_we", 64'(bus.rf_we), 64'd1);
      check("t1_waddr", 64'(bus.rf_waddr), 64'd5);
      check("t1_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
      put(0, 5'd8, 32'h0000_0008);
      put(2, 5'd10, 32'h0000_000A);
      tick();
      check("t1_next", 64'(bus.rf_waddr), 64'd10);
      tick();
      check("t1_wrap", 64'(bus.rf_waddr), 64'd8);
      drain("t1_drain");

      // all four pipes, one write per cycle
      reset_pulse();
      for (int unsigned i = 0; i < NF; i++) put(i, RW'(i + 1), 32'hA000_0000 + i);
      for (int unsigned k = 0; k < NF; k++) begin
         tick();
         check("t2_we", 64'(bus.rf_we), 64'd1);
         check("t2_waddr", 64'(bus.rf_waddr), 64'(k + 1));
      end
      tick();
      check("t2_we_end", 64'(bus.rf_we), 64'd0);

      // register-file back-pressure holds the buffer
      put(0, 5'd9, 32'h9999_0009);
      tick();
      bus.rf_ready = 1'b0;
      put(2, 5'd6, 32'h6666_0006);
      for (int unsigned k = 0; k < 3; k++) begin
         tick();
         check("t3_hold_we", 64'(bus.rf_we), 64'd1);
         check("t3_hold_addr", 64'(bus.rf_waddr), 64'd9);
         check("t3_blocked", 64'(bus.fu_ready[2]), 64'd0);
      end
      bus.rf_ready = 1'b1;
      #1 check("t3_grant", 64'(bus.fu_ready), 64'h4);
      tick();
      check("t3_waddr", 64'(bus.rf_waddr), 64'd6);
      check("t3_wdata", 64'(bus.rf_wdata), 64'h6666_0006);
      drain("t3_drain");

      // x0 dropped alongside a real grant
      put(0, 5'd0, 32'h1234_5678);
      put(2, 5'd7, 32'h7777_0007);
      #1 check("t4_ready", 64'(bus.fu_ready), 64'h5);
      tick();
      check("t4_waddr", 64'(bus.rf_waddr), 64'd7);
      put(1, 5'd13, 32'h0000_000D);
      put(3, 5'd14, 32'h0000_000E);
      #1 check("t4_next", 64'(bus.fu_ready), 64'h8);
      drain("t4_drain");

      // asynchronous reset discards the buffered write
      bus.rf_ready = 1'b0;
      put(0, 5'd11, 32'hBBBB_000B);
      tick();
      put(3, 5'd12, 32'hCCCC_000C);
      tick();
      check("t5_pre_we", 64'(bus.rf_we), 64'd1);
      #2 rst_n = 1'b0;
      #1 check("t5_async_we", 64'(bus.rf_we), 64'd0);
      check("t5_rst_ready", 64'(bus.fu_ready), 64'd0);
      tick();
      tick();
      rst_n = 1'b1;
      bus.rf_ready = 1'b1;
      #1 check("t5_regrant", 64'(bus.fu_ready), 64'h8);
      tick();
      check("t5_we", 64'(bus.rf_we), 64'd1);
      check("t5_waddr", 64'(bus.rf_waddr), 64'd12);
      drain("t5_drain");

      // three competing pipes
      reset_pulse();
      for (int unsigned i = 0; i < 3; i++) put(i, RW'(i + 1), 32'h5000_0000 + i);
      tick();
      tick();
      tick();
      drain("t6_drain");
`ifdef WB_PERF_CNT_EN
      check("t6_conflicts", 64'(conflict_cnt), 64'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Shares the single register-file write port between NUM_FUS execute pipes using round-robin arbitration.
- Sits between the execute pipe result outputs and the register file.
- Its registered output stage is also the writeback forwarding source, so results stay visible for forwarding until written.
- Results targeting x0 are acknowledged and dropped without consuming a write slot.

Parameters:
- NUM_FUS, 4, number of execute pipes (requesters); must be >= 2.
- REG_W, 5, destination register index width.
- DATA_W, 32, result width.

Ports:
- Clock and reset: clk, rst_n. One clock; reset is asynchronous and active-low.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- fu_valid  in  NUM_FUS  per-pipe result valid.
- fu_dst  in  NUM_FUS x REG_W  per-pipe destination register.
- fu_val  in  NUM_FUS x DATA_W  per-pipe result value.
- fu_ready  out  NUM_FUS  per-pipe accept (combinational).
- rf_we  out  1  write-port valid (registered).
- rf_waddr  out  REG_W  write address (registered).
- rf_wdata  out  DATA_W  write data (registered).
- rf_ready  in  1  register file accepts the write this cycle.
- conflict_cnt  out  32  ungranted-request cycle count (present only with WB_PERF_CNT_EN).

Behaviour:
- Transfer on pipe i occurs when fu_valid[i] & fu_ready[i]. The pipe holds valid/dst/val stable until transfer.
- Write request: req[i] = fu_valid[i] & (fu_dst[i] != 0).
- x0 drop: fu_valid[i] & (fu_dst[i] == 0) gives fu_ready[i] = 1 in the same cycle, independent of arbitration. No rf write, no pointer change. Several x0 requests can complete in one cycle.
- Output stage is a 1-entry buffer. It can load when out_free = !rf_we | rf_ready.
- Grant:
  - When out_free and |req, exactly one pipe is granted: the first set req bit scanning from rr_ptr upward, with wrap.
  - fu_ready[i] = grant[i] for requests with nonzero dst.
  - When !out_free, no grant is made and every nonzero-dst fu_ready is 0.
- Output register, on a grant:
  - rf_we <= 1; rf_waddr <= fu_dst[g]; rf_wdata <= fu_val[g].
  - Latency is one cycle from transfer to rf_we.
- Output register, no grant:
  - If rf_we & rf_ready, rf_we <= 0 and addr/data hold their last value.
  - If rf_we & !rf_ready, all three hold.
- Back-to-back: drain and reload in the same cycle, so a continuously ready RF sustains one write per cycle.
- rr_ptr:
  - On a grant to g, rr_ptr <= (g+1) mod NUM_FUS. Wrap from NUM_FUS-1 to 0.
  - Otherwise rr_ptr holds.
- Fairness: with rf_ready held 1, a pipe with req held is granted within NUM_FUS cycles.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, conflict_cnt=0.
- While rst_n=0, all fu_ready are forced to 0, including x0 requests.
- Reset mid-operation: a buffered write is discarded (rf_we drops asynchronously). Pipes still valid re-arbitrate from rr_ptr=0 after release.
- The pipe holding a buffered write has already transferred. It is not re-granted for that result.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- Defined:
  - conflict_cnt port exists.
  - Increments by 1 in each cycle where at least one req[i] is set and not granted, including cycles blocked by !out_free.
  - Saturates at 0xFFFF_FFFF and resets to 0.
- Undefined: port and counter logic are absent. All other behaviour is identical.

Test Plan:
1. Reset, then FU1 valid dst=5 val=0xDEADBEEF, rf_ready=1 -> fu_ready[1]=1 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; next grant starts search at FU2.
2. After reset, FU0..FU3 held valid with dst=1,2,3,4, rf_ready=1 -> grants 0,1,2,3 on consecutive cycles; rf_waddr sequence 1,2,3,4, each one cycle after its grant; rf_we high for exactly 4 cycles.
3. Buffered write dst=9; rf_ready=0 for 3 cycles while FU2 valid dst=6 -> rf_we=1 and rf_waddr=9 held, fu_ready[2]=0. In the cycle rf_ready=1, FU2 is granted; next cycle rf_waddr=6.
4. FU0 dst=0 and FU2 dst=7 valid in the same cycle -> fu_ready[0]=1 and fu_ready[2]=1; only rf_waddr=7 written; next search starts at FU3.
5. rst_n pulsed low while rf_we=1 and FU3 valid dst=12 -> rf_we=0 immediately, fu_ready=0 during reset. After release FU3 is granted and rf_waddr=12.
6. With WB_PERF_CNT_EN, FU0..FU2 valid dst=1..3 held, rf_ready=1 -> conflict_cnt=2 after all three are granted. Without the macro, the bench compiles with no conflict_cnt port.
